// File: rtl/dmem_stall_ctrl_if.sv
// Datapath <-> data-memory bundle: request side from the CPU,
// load result and stall back from the memory stage.
interface dmem_stall_ctrl_if;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] readdata;
    logic        stall;
    logic        misalign;
    logic [15:0] load_count;

    modport master (
        output memread, memwrite, addr, wdata,
        input  readdata, stall, misalign, load_count
    );

    modport slave (
        input  memread, memwrite, addr, wdata,
        output readdata, stall, misalign, load_count
    );
endinterface

// File: rtl/dmem_stall_ctrl.sv
// Word-addressed data RAM with fixed load latency; freezes the
// single-cycle CPU through stall until load data is registered.
module dmem_stall_ctrl #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic reset,
    dmem_stall_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'((LATENCY > 1) ? LATENCY - 2 : 0);

    logic [31:0]   mem_q [DEPTH];
    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          mis_q, mis_d;
    logic [15:0]   lcnt_q, lcnt_d;
    logic          st_go, ld_go, stall_c;
    logic          aligned;
    logic [AW-1:0] idx;
    logic          unused_addr;

    assign aligned     = (bus.addr[1:0] == 2'b00);
    assign idx         = bus.addr[AW+1:2];
    assign unused_addr = ^bus.addr[31:AW+2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
        lcnt_d  = lcnt_q;
        mis_d   = 1'b0;
        st_go   = 1'b0;
        ld_go   = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if ((bus.memread || bus.memwrite) && !aligned) begin
                    mis_d = 1'b1;
                end else if (bus.memwrite) begin
                    st_go = 1'b1;
                end else if (bus.memread) begin
                    stall_c = 1'b1;
                    idx_d   = idx;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                        ld_go   = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    ld_go   = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // idx_d already points at the word being completed on both paths
        if (ld_go) begin
            rdata_d = mem_q[idx_d];
            lcnt_d  = lcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            lcnt_q  <= lcnt_d;
        end
    end

    // RAM is deliberately not reset so its contents survive a CPU reset
    always_ff @(posedge clk) begin
        if (st_go && reset) begin
            mem_q[idx] <= bus.wdata;
        end
    end

    assign bus.stall      = stall_c & reset;
    assign bus.readdata   = rdata_q;
    assign bus.misalign   = mis_q;
    assign bus.load_count = lcnt_q;
endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Directed bench for dmem_stall_ctrl across LATENCY 1, 2, 4 and 15.
// Inputs change and outputs are sampled around the falling edge.
module tb_dmem_stall_ctrl;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   n_st;

    dmem_stall_ctrl_if b1 ();
    dmem_stall_ctrl_if b2 ();
    dmem_stall_ctrl_if b4 ();
    dmem_stall_ctrl_if b15 ();

    dmem_stall_ctrl #(.DEPTH(64), .LATENCY(1))  u1  (.clk(clk), .reset(rst_n), .bus(b1));
    dmem_stall_ctrl #(.DEPTH(64), .LATENCY(2))  u2  (.clk(clk), .reset(rst_n), .bus(b2));
    dmem_stall_ctrl #(.DEPTH(64), .LATENCY(4))  u4  (.clk(clk), .reset(rst_n), .bus(b4));
    dmem_stall_ctrl #(.DEPTH(64), .LATENCY(15)) u15 (.clk(clk), .reset(rst_n), .bus(b15));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        b1.memread = 0;  b1.memwrite = 0;  b1.addr = 0;  b1.wdata = 0;
        b2.memread = 0;  b2.memwrite = 0;  b2.addr = 0;  b2.wdata = 0;
        b4.memread = 0;  b4.memwrite = 0;  b4.addr = 0;  b4.wdata = 0;
        b15.memread = 0; b15.memwrite = 0; b15.addr = 0; b15.wdata = 0;

        repeat (3) @(negedge clk);
        b2.memread = 1;
        #1 chk("stall_in_reset", b2.stall, 0);
        b2.memread = 0;
        rst_n = 1'b1;
        #1;
        chk("rst_readdata", b2.readdata, 0);
        chk("rst_stall", b2.stall, 0);
        chk("rst_misalign", b2.misalign, 0);
        chk("rst_load_count", b2.load_count, 0);

        // stores into every instance
        @(negedge clk);
        b2.memwrite = 1;  b2.addr = 32'h10;  b2.wdata = 32'hDEADBEEF;
        b4.memwrite = 1;  b4.addr = 32'h10;  b4.wdata = 32'hDEADBEEF;
        b1.memwrite = 1;  b1.addr = 32'h4;   b1.wdata = 32'h11111111;
        b15.memwrite = 1; b15.addr = 32'h4;  b15.wdata = 32'h15151515;
        #1 chk("store_no_stall", b2.stall, 0);

        @(negedge clk);
        b2.memwrite = 0;  b4.memwrite = 0;  b1.memwrite = 0;  b15.memwrite = 0;
        b2.memread = 1;   b2.addr = 32'h10;
        b1.memread = 1;   b1.addr = 32'h4;
        #1;
        chk("l2_stall_c0", b2.stall, 1);
        chk("l1_stall_c0", b1.stall, 1);

        @(negedge clk);
        b2.memread = 0;
        b1.memread = 0;
        #1;
        chk("l2_stall_c1", b2.stall, 1);
        chk("l1_done_stall", b1.stall, 0);
        chk("l1_done_data", b1.readdata, 32'h11111111);
        chk("l1_done_count", b1.load_count, 1);

        @(negedge clk);
        #1;
        chk("l2_done_stall", b2.stall, 0);
        chk("l2_done_data", b2.readdata, 32'hDEADBEEF);
        chk("l2_done_count", b2.load_count, 1);

        // LATENCY=15: count stall cycles, bounded
        @(negedge clk);
        b15.memread = 1;
        b15.addr = 32'h4;
        n_st = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!b15.stall) break;
            n_st++;
            @(negedge clk);
            b15.memread = 0;
        end
        chk("l15_stall_cycles", n_st, 15);
        chk("l15_done_data", b15.readdata, 32'h15151515);
        @(negedge clk);
        #1 chk("l15_after_stall", b15.stall, 0);

        // index wrap: 0x100 aliases word 0 with DEPTH=64
        @(negedge clk);
        b2.memwrite = 1; b2.addr = 32'h100; b2.wdata = 32'h12345678;
        @(negedge clk);
        b2.memwrite = 0; b2.memread = 1; b2.addr = 32'h0;
        @(negedge clk);
        b2.memread = 0;
        @(negedge clk);
        #1;
        chk("wrap_data", b2.readdata, 32'h12345678);
        chk("wrap_count", b2.load_count, 2);

        // misaligned store dropped
        @(negedge clk);
        b2.memwrite = 1; b2.addr = 32'h102; b2.wdata = 32'hFFFFFFFF;
        #1 chk("mis_no_stall", b2.stall, 0);
        @(negedge clk);
        b2.memwrite = 0;
        #1 chk("mis_pulse", b2.misalign, 1);
        @(negedge clk);
        #1 chk("mis_clear", b2.misalign, 0);
        b2.memread = 1; b2.addr = 32'h0;
        @(negedge clk);
        b2.memread = 0;
        @(negedge clk);
        #1;
        chk("mis_word0_kept", b2.readdata, 32'h12345678);
        chk("mis_count", b2.load_count, 3);

        // read+write together acts as a store
        @(negedge clk);
        b2.memread = 1; b2.memwrite = 1; b2.addr = 32'h8; b2.wdata = 32'hA5A5A5A5;
        #1 chk("rw_no_stall", b2.stall, 0);
        @(negedge clk);
        b2.memread = 0; b2.memwrite = 0;
        #1;
        chk("rw_readdata_held", b2.readdata, 32'h12345678);
        chk("rw_count_held", b2.load_count, 3);
        chk("rw_idle_stall", b2.stall, 0);
        b2.memread = 1; b2.addr = 32'h8;
        @(negedge clk);
        b2.memread = 0;
        @(negedge clk);
        #1;
        chk("rw_load_data", b2.readdata, 32'hA5A5A5A5);
        chk("rw_load_count", b2.load_count, 4);

        // reset in the second WAIT cycle of a LATENCY=4 load
        @(negedge clk);
        b4.memread = 1; b4.addr = 32'h10;
        #1 chk("l4_stall_c0", b4.stall, 1);
        @(negedge clk);
        b4.memread = 0;
        #1 chk("l4_stall_c1", b4.stall, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_stall", b4.stall, 0);
        chk("abort_readdata", b4.readdata, 0);
        chk("abort_count", b4.load_count, 0);
        chk("abort_l2_data", b2.readdata, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        b4.memread = 1; b4.addr = 32'h10;
        @(negedge clk);
        b4.memread = 0;
        @(negedge clk);
        @(negedge clk);
        #1 chk("l4_stall_c3", b4.stall, 1);
        @(negedge clk);
        #1;
        chk("l4_done_stall", b4.stall, 0);
        chk("l4_done_data", b4.readdata, 32'hDEADBEEF);
        chk("l4_done_count", b4.load_count, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
